// File: rtl/elbeth_pipeline_ctrl_pkg.sv
// Shared constants and types for the ELBETH pipeline stall/flush sequencer.
package elbeth_pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_W  = 5;
   localparam int unsigned CAUSE_W     = 4;
   localparam int unsigned PC_SEL_W    = 2;
   localparam int unsigned DRAIN_CNT_W = 2;

   localparam logic [PC_SEL_W-1:0] PC_SEL_NEXT   = 2'd0;
   localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [PC_SEL_W-1:0] PC_SEL_TRAP   = 2'd2;
   localparam logic [PC_SEL_W-1:0] PC_SEL_ERET   = 2'd3;

   localparam logic [CAUSE_W-1:0] ECODE_ILLEGAL_INST = 4'h2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TRAP  = 2'd2,
      ST_ERET  = 2'd3
   } state_e;

   // One enable per pipeline stage register.
   typedef struct packed {
      logic if_s;
      logic id_s;
      logic ex_s;
      logic mem_s;
   } stage_vec_t;

endpackage

// File: rtl/elbeth_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands of ID.
module elbeth_hazard_detect
   import elbeth_pipeline_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_mem_read,
   output logic                  load_use_hazard
);

   // x0 never carries a dependency; rs2 only matters when the ID instruction reads it.
   always_comb begin
      load_use_hazard = ex_mem_read
                        && (ex_rd_addr != '0)
                        && ((ex_rd_addr == id_rs1_addr)
                            || (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
   end

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Central stall/flush sequencer for the ELBETH 5-stage in-order core.
module elbeth_pipeline_ctrl
   import elbeth_pipeline_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned PERF_WIDTH   = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_mem_read,
   input  logic                  ex_take_branch,
   input  logic                  id_illegal_instruction,
   input  logic [CAUSE_W-1:0]    id_except_src,
   input  logic                  id_eret,
   input  logic                  mem_except,
   input  logic [CAUSE_W-1:0]    mem_except_src,
   input  logic                  imem_ready,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  if_stall,
   output logic                  id_stall,
   output logic                  ex_stall,
   output logic                  mem_stall,
   output logic                  if_flush,
   output logic                  id_flush,
   output logic                  ex_flush,
   output logic                  mem_flush,
   output logic [PC_SEL_W-1:0]   pc_sel,
   output logic                  csr_exception,
   output logic [CAUSE_W-1:0]    csr_exception_cause,
   output logic                  csr_eret,
   output logic [PERF_WIDTH-1:0] stall_cycles
);

   state_e                  state_q, state_d;
   logic [DRAIN_CNT_W-1:0]  cnt_q, cnt_d;
   logic [CAUSE_W-1:0]      cause_q, cause_d;
   logic [PERF_WIDTH-1:0]   stall_cycles_q, stall_cycles_d;

   stage_vec_t              stall_c, flush_c;
   logic                    load_use_hazard;
   logic                    dmem_wait;

   elbeth_hazard_detect u_hazard (
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd_addr      (ex_rd_addr),
      .ex_mem_read     (ex_mem_read),
      .load_use_hazard (load_use_hazard)
   );

   assign dmem_wait = dmem_req && !dmem_ready;

   // Next-state and stage-control decode; a data-memory wait freezes everything.
   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      cause_d             = cause_q;
      stall_c             = '0;
      flush_c             = '0;
      pc_sel              = PC_SEL_NEXT;
      csr_exception       = 1'b0;
      csr_exception_cause = '0;
      csr_eret            = 1'b0;

      if (rst) begin
         flush_c = '1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (dmem_wait) begin
                  stall_c = '1;
               end else if (mem_except) begin
                  csr_exception       = 1'b1;
                  csr_exception_cause = mem_except_src;
                  flush_c             = '1;
                  pc_sel              = PC_SEL_TRAP;
               end else if (id_illegal_instruction) begin
                  stall_c.if_s = 1'b1;
                  stall_c.id_s = 1'b1;
                  flush_c.ex_s = 1'b1;
                  cause_d      = id_except_src;
                  cnt_d        = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                  state_d      = ST_DRAIN;
               end else if (id_eret) begin
                  stall_c.if_s = 1'b1;
                  stall_c.id_s = 1'b1;
                  flush_c.ex_s = 1'b1;
                  state_d      = ST_ERET;
               end else if (ex_take_branch) begin
                  pc_sel       = PC_SEL_BRANCH;
                  flush_c.if_s = 1'b1;
                  flush_c.id_s = 1'b1;
               end else if (load_use_hazard) begin
                  stall_c.if_s = 1'b1;
                  stall_c.id_s = 1'b1;
                  flush_c.ex_s = 1'b1;
               end else if (!imem_ready) begin
                  stall_c.if_s = 1'b1;
                  flush_c.id_s = 1'b1;
               end
            end
            ST_DRAIN: begin
               if (dmem_wait) begin
                  stall_c = '1;
               end else if (mem_except) begin
                  // An older faulting instruction outranks the pending ID trap.
                  csr_exception       = 1'b1;
                  csr_exception_cause = mem_except_src;
                  flush_c             = '1;
                  pc_sel              = PC_SEL_TRAP;
                  cause_d             = '0;
                  cnt_d               = '0;
                  state_d             = ST_RUN;
               end else begin
                  stall_c.if_s = 1'b1;
                  stall_c.id_s = 1'b1;
                  flush_c.ex_s = 1'b1;
                  if (cnt_q == '0) begin
                     state_d = ST_TRAP;
                  end else begin
                     cnt_d = cnt_q - DRAIN_CNT_W'(1);
                  end
               end
            end
            ST_TRAP: begin
               csr_exception       = 1'b1;
               csr_exception_cause = cause_q;
               flush_c             = '1;
               pc_sel              = PC_SEL_TRAP;
               cause_d             = '0;
               state_d             = ST_RUN;
            end
            ST_ERET: begin
               csr_eret     = 1'b1;
               pc_sel       = PC_SEL_ERET;
               flush_c.if_s = 1'b1;
               flush_c.id_s = 1'b1;
               flush_c.ex_s = 1'b1;
               state_d      = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // A flushed stage must load the bubble, so flush masks stall.
   always_comb begin
      if_stall  = stall_c.if_s  && !flush_c.if_s;
      id_stall  = stall_c.id_s  && !flush_c.id_s;
      ex_stall  = stall_c.ex_s  && !flush_c.ex_s;
      mem_stall = stall_c.mem_s && !flush_c.mem_s;
      if_flush  = flush_c.if_s;
      id_flush  = flush_c.id_s;
      ex_flush  = flush_c.ex_s;
      mem_flush = flush_c.mem_s;
   end

   // Stall-cycle counter wraps naturally at its width.
   always_comb begin
      stall_cycles_d = stall_cycles_q + PERF_WIDTH'(id_stall);
   end

   assign stall_cycles = stall_cycles_q;

   // State, drain counter, latched cause and perf counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_RUN;
         cnt_q          <= '0;
         cause_q        <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cause_q        <= cause_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Directed, scoreboard-based bench for the ELBETH pipeline sequencer.
module tb_elbeth_pipeline_ctrl;
   import elbeth_pipeline_ctrl_pkg::*;

   localparam int unsigned PW = 4;

   logic            clk;
   logic            rst;
   logic [4:0]      id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic            id_uses_rs2, ex_mem_read, ex_take_branch;
   logic            id_illegal_instruction, id_eret, mem_except;
   logic [3:0]      id_except_src, mem_except_src;
   logic            imem_ready, dmem_req, dmem_ready;
   logic            if_stall, id_stall, ex_stall, mem_stall;
   logic            if_flush, id_flush, ex_flush, mem_flush;
   logic [1:0]      pc_sel;
   logic            csr_exception, csr_eret;
   logic [3:0]      csr_exception_cause;
   logic [PW-1:0]   stall_cycles;

   int              checks = 0;
   int              errors = 0;
   logic [PW-1:0]   perf_exp = '0;

   logic [15:0]     exp_q[$];
   string           tag_q[$];

   elbeth_pipeline_ctrl #(.DRAIN_CYCLES(2), .PERF_WIDTH(PW)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .id_rs1_addr            (id_rs1_addr),
      .id_rs2_addr            (id_rs2_addr),
      .id_uses_rs2            (id_uses_rs2),
      .ex_rd_addr             (ex_rd_addr),
      .ex_mem_read            (ex_mem_read),
      .ex_take_branch         (ex_take_branch),
      .id_illegal_instruction (id_illegal_instruction),
      .id_except_src          (id_except_src),
      .id_eret                (id_eret),
      .mem_except             (mem_except),
      .mem_except_src         (mem_except_src),
      .imem_ready             (imem_ready),
      .dmem_req               (dmem_req),
      .dmem_ready             (dmem_ready),
      .if_stall               (if_stall),
      .id_stall               (id_stall),
      .ex_stall               (ex_stall),
      .mem_stall              (mem_stall),
      .if_flush               (if_flush),
      .id_flush               (id_flush),
      .ex_flush               (ex_flush),
      .mem_flush              (mem_flush),
      .pc_sel                 (pc_sel),
      .csr_exception          (csr_exception),
      .csr_exception_cause    (csr_exception_cause),
      .csr_eret               (csr_eret),
      .stall_cycles           (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector: {stall if,id,ex,mem | flush if,id,ex,mem | pc_sel | exc | cause | eret}
   function automatic logic [15:0] mk(input logic [3:0] st, input logic [3:0] fl,
                                      input logic [1:0] pc, input logic ex,
                                      input logic [3:0] cause, input logic er);
      return {st, fl, pc, ex, cause, er};
   endfunction

   task automatic set_idle();
      id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs2 = 1'b0;
      ex_rd_addr = '0; ex_mem_read = 1'b0; ex_take_branch = 1'b0;
      id_illegal_instruction = 1'b0; id_except_src = '0; id_eret = 1'b0;
      mem_except = 1'b0; mem_except_src = '0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   // Push expectation for the cycle just driven, compare at negedge, then advance.
   task automatic step(input string tag, input logic [15:0] e);
      logic [15:0] got, want;
      string       t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      got  = {if_stall, id_stall, ex_stall, mem_stall,
              if_flush, id_flush, ex_flush, mem_flush,
              pc_sel, csr_exception, csr_exception_cause, csr_eret};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", t, got, want);
      end
      @(posedge clk);
      if (rst) perf_exp = '0;
      else if (want[14]) perf_exp = perf_exp + 1'b1;
      #1;
   endtask

   task automatic check_perf(input string tag);
      checks++;
      assert (stall_cycles === perf_exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, stall_cycles, perf_exp);
      end
   endtask

   localparam logic [15:0] IDLE = 16'h0000;

   initial begin
      set_idle();
      rst = 1'b1;
      @(posedge clk); #1;
      step("reset_out", mk(4'b0000, 4'b1111, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      check_perf("perf_reset");
      rst = 1'b0;
      step("idle", IDLE);

      // load x5 in EX, ID add x6,x5,x1 -> one bubble
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs2_addr = 5'd1; id_uses_rs2 = 1'b1;
      step("load_use_rs1", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
      step("after_bubble", IDLE);
      check_perf("perf_one_bubble");

      // rs2 dependency counts only when rs2 is read
      ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1;
      step("load_use_rs2", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      id_uses_rs2 = 1'b0;
      step("rs2_unused", IDLE);

      // load to x0 never stalls
      ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
      step("load_x0", IDLE);

      // taken branch beats load-use hazard
      ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; ex_take_branch = 1'b1;
      step("branch_over_hazard", mk(4'b0000, 4'b1100, PC_SEL_BRANCH, 1'b0, 4'h0, 1'b0));
      set_idle();

      // fetch miss
      imem_ready = 1'b0;
      step("imem_wait", mk(4'b1000, 4'b0100, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      set_idle();
      check_perf("perf_mid");

      // illegal instruction: detect, 2 drain cycles, trap with latched cause
      id_illegal_instruction = 1'b1; id_except_src = ECODE_ILLEGAL_INST;
      step("illegal_detect", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      id_except_src = 4'hF;
      step("drain_1", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      step("drain_2", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      set_idle();
      step("illegal_trap", mk(4'b0000, 4'b1111, PC_SEL_TRAP, 1'b1, ECODE_ILLEGAL_INST, 1'b0));
      step("post_trap", IDLE);
      check_perf("perf_after_trap");

      // MEM exception preempts drain; ID cause is dropped
      id_illegal_instruction = 1'b1; id_except_src = 4'h2;
      step("illegal_detect2", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      mem_except = 1'b1; mem_except_src = 4'h4;
      step("mem_preempt", mk(4'b0000, 4'b1111, PC_SEL_TRAP, 1'b1, 4'h4, 1'b0));
      set_idle();
      step("no_stale_trap_a", IDLE);
      step("no_stale_trap_b", IDLE);

      // dmem wait beats mem_except in RUN
      dmem_req = 1'b1; dmem_ready = 1'b0; mem_except = 1'b1; mem_except_src = 4'h5;
      step("dmem_over_mem_exc", mk(4'b1111, 4'b0000, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      set_idle();

      // dmem wait during drain holds the counter
      id_illegal_instruction = 1'b1; id_except_src = 4'h9;
      step("illegal_detect3", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      dmem_req = 1'b1; dmem_ready = 1'b0;
      step("drain_dmem_hold", mk(4'b1111, 4'b0000, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      dmem_req = 1'b0; dmem_ready = 1'b1;
      step("drain_3a", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      step("drain_3b", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      set_idle();
      step("trap_cause9", mk(4'b0000, 4'b1111, PC_SEL_TRAP, 1'b1, 4'h9, 1'b0));

      // eret under a 3-cycle data wait
      dmem_req = 1'b1; dmem_ready = 1'b0; id_eret = 1'b1;
      for (int i = 0; i < 3; i++)
         step("eret_dmem_wait", mk(4'b1111, 4'b0000, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      dmem_req = 1'b0; dmem_ready = 1'b1;
      step("eret_detect", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      id_eret = 1'b0;
      step("eret_strobe", mk(4'b0000, 4'b1110, PC_SEL_ERET, 1'b0, 4'h0, 1'b1));
      step("post_eret", IDLE);
      check_perf("perf_after_eret");

      // long data wait forces the perf counter through its wrap
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 18; i++)
         step("long_wait", mk(4'b1111, 4'b0000, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      set_idle();
      check_perf("perf_wrap");

      // reset mid-eret and mid-drain aborts the sequence
      id_eret = 1'b1;
      step("eret_detect_rst", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      rst = 1'b1; id_eret = 1'b0;
      step("rst_mid_eret", mk(4'b0000, 4'b1111, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      rst = 1'b0;
      step("no_eret_after_rst", IDLE);
      check_perf("perf_after_rst");
      id_illegal_instruction = 1'b1; id_except_src = 4'h2;
      step("illegal_detect_rst", mk(4'b1100, 4'b0010, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      rst = 1'b1; id_illegal_instruction = 1'b0;
      step("rst_mid_drain", mk(4'b0000, 4'b1111, PC_SEL_NEXT, 1'b0, 4'h0, 1'b0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++)
         step("no_trap_after_rst", IDLE);
      check_perf("perf_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/elbeth_pipeline_ctrl.md
Name: elbeth_pipeline_ctrl

Overview:
Central stall/flush sequencer for the ELBETH 5-stage in-order core (IF, ID, EX, MEM, WB). It consumes decoder results (register addresses, illegal-instruction/exception source, eret) and EX/MEM status. It produces per-stage stall and flush enables, the PC source select and CSR-file trap/eret strobes. A small FSM drains older instructions before an ID-stage trap is taken and sequences trap and eret redirects.

Parameters:
DRAIN_CYCLES, 2, cycles spent draining EX/MEM before taking an ID-stage exception (1..3)
PERF_WIDTH, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_rs1_addr  in  5  rs1 of instruction in ID
id_rs2_addr  in  5  rs2 of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd_addr  in  5  destination of instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_take_branch  in  1  branch/JAL/JALR in EX resolved taken
id_illegal_instruction  in  1  decoder illegal flag
id_except_src  in  4  decoder exception code
id_eret  in  1  decoder eret
mem_except  in  1  MEM-stage exception (misaligned/access fault)
mem_except_src  in  4  MEM exception code
imem_ready  in  1  instruction fetch complete
dmem_req  in  1  MEM stage has an active data access
dmem_ready  in  1  data access complete
if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold stage register
if_flush, id_flush, ex_flush, mem_flush  out  1 each  load bubble into stage register
pc_sel  out  2  PC_SEL_NEXT=0, PC_SEL_BRANCH=1, PC_SEL_TRAP=2, PC_SEL_ERET=3
csr_exception  out  1  one-cycle strobe: CSR file records trap
csr_exception_cause  out  4  cause accompanying csr_exception
csr_eret  out  1  one-cycle strobe: CSR file pops privilege
stall_cycles  out  PERF_WIDTH  count of cycles with id_stall asserted

Behaviour:
- States: ST_RUN, ST_DRAIN, ST_TRAP, ST_ERET. The state is registered. All stall/flush/pc_sel/strobe outputs are combinational from the state and inputs.
- Reset (rst=1 at a clk edge): state=ST_RUN, drain counter=0, stall_cycles=0, latched cause=0. While rst is high, all flushes=1, all stalls=0, pc_sel=0, strobes=0.
- ST_RUN priority, highest first:
  1. dmem_req&!dmem_ready: all four stalls=1, no flushes, pc_sel=NEXT. This wins even over mem_except.
  2. mem_except: csr_exception=1 this cycle; cause=mem_except_src; if/id/ex/mem_flush=1; pc_sel=TRAP. State stays ST_RUN.
  3. id_illegal_instruction: latch cause=id_except_src; if_stall=id_stall=1; ex_flush=1; next state ST_DRAIN; counter=DRAIN_CYCLES-1.
  4. id_eret: if_stall=id_stall=1; ex_flush=1; next state ST_ERET.
  5. ex_take_branch: pc_sel=BRANCH; if_flush=id_flush=1. A hazard against the squashed ID instruction is ignored.
  6. Load-use, where ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | (id_uses_rs2 & ex_rd_addr==id_rs2_addr)): if_stall=id_stall=1; ex_flush=1. Exactly one bubble per hazard.
  7. !imem_ready: if_stall=1; id_flush=1.
- ST_DRAIN: if_stall=id_stall=1; ex_flush=1; counter decrements; at 0, next state ST_TRAP. A mem_except during drain preempts: take rule 2, return to ST_RUN, and drop the latched ID cause. A dmem wait stalls the counter.
- ST_TRAP (1 cycle): csr_exception=1 with the latched cause; pc_sel=TRAP; if/id/ex/mem_flush=1; next state ST_RUN.
- ST_ERET (1 cycle): csr_eret=1; pc_sel=ERET; if/id/ex_flush=1; next state ST_RUN.
- Simultaneous stall and flush on the same stage: flush wins.
- stall_cycles increments whenever id_stall=1 and wraps at 2^PERF_WIDTH-1→0.

Decomposition:
- elbeth_definitions.v gains PC_SEL_* and ST_RUN/ST_DRAIN/ST_TRAP/ST_ERET constants. It reuses ECODE_ILLEGAL_INST.
- One combinational sub-module, elbeth_hazard_detect, does the load-use compare and outputs load_use_hazard.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1 → exactly one cycle with if_stall=id_stall=ex_flush=1, then the pipeline flows; stall_cycles=1.
- Load to x0 in EX with ID rs1=0 → no stall.
- ex_take_branch=1 together with a load-use hazard → pc_sel=1, if_flush=id_flush=1, no stalls.
- id_illegal_instruction with cause 4'h2, DRAIN_CYCLES=2 → 2 drain cycles, then 1 cycle with csr_exception=1, cause=2, pc_sel=2, all flushes=1; back to ST_RUN.
- mem_except (cause 4'h4) arriving in the 1st drain cycle → immediate trap with cause 4, no later strobe carrying cause 2.
- dmem_req=1, dmem_ready=0 for 3 cycles concurrent with id_eret → 3 full-stall cycles, then ID-stall + ex_flush cycle, then csr_eret=1, pc_sel=3; rst asserted mid-sequence → next cycle ST_RUN, all flushes=1, counter=0.
